// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared state/opcode encodings for the multicycle control path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  // The decoder consumes these exact values, so they are part of the interface.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic state_t boundary_target(input logic halt_req);
    return halt_req ? S_HALT : S_FETCH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_mem_watchdog.sv
// ============================================================================
// Module : mc_mem_watchdog
// Brief  : Counts stalled memory-wait cycles and flags expiry at WAIT_MAX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_mem_watchdog #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire
);

  localparam logic [7:0] c_last = 8'(WAIT_MAX - 1);

  logic [7:0] r_cnt;

  // Every exit from a wait state is either mem_ready or a move to a non-wait
  // state, so clearing on those covers "clear on entry" for back-to-back waits.
  always_ff @(posedge clk) begin
    if (rst || !waiting || mem_ready) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expire = waiting && !mem_ready && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/mc_state_seq.sv
// ============================================================================
// Module : mc_state_seq
// Brief  : Main-control sequencer; state register, next-state, status flags.
//          Optional perf counters enabled by defining MC_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_state_seq
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_err,
  output logic       retire
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255 || CNT_W < 1) begin : g_param_check
    $error("mc_state_seq: WAIT_MAX must be 1..255 and CNT_W >= 1");
  end

  state_t r_state;
  state_t w_next;
  logic   r_halted;
  logic   r_illegal;
  logic   r_bus_err;
  logic   r_retire;
  logic   w_set_illegal;
  logic   w_waiting;
  logic   w_expire;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  mc_mem_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .waiting   (w_waiting),
    .mem_ready (mem_ready),
    .expire    (w_expire)
  );

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    if (w_expire) begin
      w_next = S_TRAP;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) w_next = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXEC;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI:      w_next = S_ADDIEX;
            OP_J:         w_next = S_JUMP;
            default: begin
              w_next        = S_TRAP;
              w_set_illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW) begin
            w_next = S_MEMRD;
          end else if (opcode == OP_SW) begin
            w_next = S_MEMWR;
          end else begin
            w_next        = S_TRAP;
            w_set_illegal = 1'b1;
          end
        end
        S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
        S_MEMWR:  if (mem_ready) w_next = boundary_target(halt_req);
        S_EXEC:   w_next = S_ALUWB;
        S_ADDIEX: w_next = S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                  w_next = boundary_target(halt_req);
        S_HALT:   if (!halt_req) w_next = S_FETCH;
        S_TRAP:   w_next = S_TRAP;
        default:  w_next = boundary_target(halt_req);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retire  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_halted  <= (w_next == S_HALT) || (w_next == S_TRAP);
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_expire;
      r_retire  <= (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
                   (r_state == S_ADDIWB) || (r_state == S_JUMP) ||
                   ((r_state == S_MEMWR) && mem_ready);
    end
  end

  assign state      = r_state;
  assign halted     = r_halted;
  assign illegal_op = r_illegal;
  assign bus_err    = r_bus_err;
  assign retire     = r_retire;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  // A retire pulse can land in the first HALT cycle; it still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (!((r_state == S_HALT) || (r_state == S_TRAP))) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (r_retire) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_state_seq.sv
// ============================================================================
// Module : tb_mc_state_seq
// Brief  : Directed self-checking bench for mc_state_seq (WAIT_MAX = 8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_state_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       halt_req;
  logic [3:0] state;
  logic       halted;
  logic       illegal_op;
  logic       bus_err;
  logic       retire;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [3:0]  s4;
  logic        h4, il4, be4, rt4;
  logic [3:0]  cyc4;
  logic [3:0]  ins4;
`endif

  mc_state_seq #(
    .WAIT_MAX (8),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .state      (state),
    .halted     (halted),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .retire     (retire)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

`ifdef MC_PERF_CNT_EN
  mc_state_seq #(
    .WAIT_MAX (8),
    .CNT_W    (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .state      (s4),
    .halted     (h4),
    .illegal_op (il4),
    .bus_err    (be4),
    .retire     (rt4),
    .cycle_cnt  (cyc4),
    .instr_cnt  (ins4)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    opcode    = 6'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b want 0", retire); end
  endtask

  task automatic test_lw;
    logic [3:0] exp [5];
    int rcnt;
    exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    rcnt = 0;
    do_reset();
    opcode    = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (retire === 1'b1) rcnt++;
      n_cmp++;
      if (state !== exp[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp[i]); end
    end
    n_cmp++; if (rcnt != 1) begin n_fail++; $display("FAIL lw_retire_count: got %0d want 1", rcnt); end
    n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL lw_retire_last: got %b want 1", retire); end
    // abandon the next lw mid-flight in MEMRD
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'd3) begin n_fail++; $display("FAIL lw_pre_abort: got %0d want 3", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL lw_abort_state: got %0d want 0", state); end
    n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL lw_abort_retire: got %b want 0", retire); end
  endtask

  task automatic test_rtype_j;
    logic [3:0] exp [7];
    logic [5:0] ops [7];
    logic       rexp [7];
    int rcnt;
    exp  = '{4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd11, 4'd0};
    ops  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000010, 6'b000010};
    rexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rcnt = 0;
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      tick();
      if (retire === 1'b1) rcnt++;
      n_cmp++;
      if (state !== exp[i]) begin n_fail++; $display("FAIL rj_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      n_cmp++;
      if (retire !== rexp[i]) begin n_fail++; $display("FAIL rj_retire[%0d]: got %b want %b", i, retire, rexp[i]); end
    end
    n_cmp++; if (rcnt != 2) begin n_fail++; $display("FAIL rj_retire_count: got %0d want 2", rcnt); end
  endtask

  task automatic test_sw_wait;
    do_reset();
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'd5) begin n_fail++; $display("FAIL sw_enter: got %0d want 5", state); end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (state !== 4'd5) begin n_fail++; $display("FAIL sw_hold[%0d]: got %0d want 5", i, state); end
    end
    mem_ready = 1'b1;
    tick();
    n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL sw_exit: got %0d want 0", state); end
    n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL sw_retire: got %b want 1", retire); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL sw_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_watchdog;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL wd_wait[%0d]: got %0d want 0", i, state); end
    end
    tick();
    n_cmp++; if (state !== 4'd13) begin n_fail++; $display("FAIL wd_trap: got %0d want 13", state); end
    n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL wd_bus_err: got %b want 1", bus_err); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL wd_halted: got %b want 1", halted); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'd13) begin n_fail++; $display("FAIL wd_stay: got %0d want 13", state); end
    n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b want 1", bus_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL wd_rst_state: got %0d want 0", state); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL wd_rst_bus_err: got %b want 0", bus_err); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wd_rst_halted: got %b want 0", halted); end
  endtask

  task automatic test_watchdog_tie;
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    mem_ready = 1'b1;
    tick();
    n_cmp++; if (state !== 4'd1) begin n_fail++; $display("FAIL tie_state: got %0d want 1", state); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tie_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_illegal;
    do_reset();
    opcode    = 6'b111111;
    mem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (state !== 4'd13) begin n_fail++; $display("FAIL ill_state: got %0d want 13", state); end
    n_cmp++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", illegal_op); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halted: got %b want 1", halted); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ill_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_halt;
    do_reset();
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'd7) begin n_fail++; $display("FAIL halt_pre: got %0d want 7", state); end
    halt_req = 1'b1;
    tick();
    n_cmp++; if (state !== 4'd12) begin n_fail++; $display("FAIL halt_enter: got %0d want 12", state); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL halt_retire: got %b want 1", retire); end
    tick();
    n_cmp++; if (state !== 4'd12) begin n_fail++; $display("FAIL halt_hold: got %0d want 12", state); end
    halt_req = 1'b0;
    tick();
    n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL halt_exit: got %0d want 0", state); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_release: got %b want 0", halted); end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf;
    do_reset();
    n_cmp++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_rst_cycle: got %0d want 0", cycle_cnt); end
    opcode    = 6'b000100;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    opcode = 6'b001000;
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'd10) begin n_fail++; $display("FAIL perf_addiwb: got %0d want 10", state); end
    halt_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (instr_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_instr: got %0d want 2", instr_cnt); end
    n_cmp++; if (cycle_cnt !== 32'd7) begin n_fail++; $display("FAIL perf_cycle: got %0d want 7", cycle_cnt); end
    do_reset();
    opcode    = 6'b000100;
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (cycle_cnt !== 32'd20) begin n_fail++; $display("FAIL perf_cycle20: got %0d want 20", cycle_cnt); end
    n_cmp++; if (instr_cnt !== 32'd6) begin n_fail++; $display("FAIL perf_instr20: got %0d want 6", instr_cnt); end
    n_cmp++; if (cyc4 !== 4'd4) begin n_fail++; $display("FAIL perf_cycle_wrap: got %0d want 4", cyc4); end
    n_cmp++; if (ins4 !== 4'd6) begin n_fail++; $display("FAIL perf_instr_w4: got %0d want 6", ins4); end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_rtype_j();
    test_sw_wait();
    test_watchdog();
    test_watchdog_tie();
    test_illegal();
    test_halt();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_state_seq.md
Name: mc_state_seq

Overview:
- Main-control sequencer for the multicycle MIPS core.
- Holds the 4-bit state register and computes next state from opcode, memory handshake, halt request and a memory watchdog.
- Its `state` output drives the existing combinational control-output decoder, which produces all datapath strobes.
- Owns only sequencing; emits no datapath strobes itself.

Parameters:
- WAIT_MAX, 8, maximum cycles a memory state may wait for mem_ready before bus-error halt; 1..255.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from state 1 onward.
- mem_ready  input  1  memory completed access this cycle.
- halt_req  input  1  debug halt request, level-sensitive.
- state  output  4  current control state to the decoder.
- halted  output  1  core parked in HALT or TRAP.
- illegal_op  output  1  sticky; unknown opcode decoded.
- bus_err  output  1  sticky; memory watchdog expired.
- retire  output  1  one-cycle pulse on instruction completion.

Behaviour:
- Reset: state=0, halted=0, illegal_op=0, bus_err=0, retire=0, wait counter=0. Reset mid-instruction abandons it; the next cycle is state 0.
- State encoding, fixed and shared with the decoder:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 EXEC, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP
  - 12 HALT, 13 TRAP; 14 and 15 unused, decode to 0.
- Transitions:
  - 0 -> 1 when mem_ready, else hold.
  - 1 -> by opcode: 100011 (lw) or 101011 (sw) -> 2; 000000 -> 6; 000100 -> 8; 001000 -> 9; 000010 -> 11; any other -> 13 with illegal_op set.
  - 2 -> 3 if lw, -> 5 if sw (opcode re-examined).
  - 3 -> 4 when mem_ready, else hold.
  - 5 -> 0 when mem_ready, else hold.
  - 6 -> 7. 9 -> 10.
  - 4, 7, 8, 10, 11 -> 0.
  - 12 -> 0 when halt_req=0.
  - 13 holds until rst.
- Instruction boundary: any transition whose target is 0 goes to 12 instead if halt_req=1 that cycle.
- retire: pulses in the cycle after leaving 4, 5 (with mem_ready), 7, 8, 10 or 11.
- Memory watchdog:
  - Counter clears on entry to 0, 3 or 5; increments each cycle held there with mem_ready=0.
  - Reaching WAIT_MAX while still waiting -> state 13, bus_err set.
  - mem_ready on the same cycle as expiry wins: normal transition, no error.
- halted=1 in states 12 and 13.
- Unused encodings 14/15, reachable only via upset, go to 0 next cycle.
- Latency: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, plus memory wait cycles.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- With it defined, adds outputs `cycle_cnt[CNT_W-1:0]` and `instr_cnt[CNT_W-1:0]`:
  - cycle_cnt increments every cycle not in states 12/13.
  - instr_cnt increments on retire.
  - Both wrap at 2^CNT_W, clear on rst, and hold while halted.
- Without it: ports and logic absent; all other behaviour identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state constants S_FETCH..S_TRAP;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the 4-bit state typedef.
- The package is imported by this block and by the control-output decoder so encodings cannot drift.
- One sub-module, mc_mem_watchdog: wait counter plus expiry compare, with inputs clk, rst, waiting, mem_ready and output expire.

Test Plan:
- lw, opcode 100011, mem_ready always 1 -> state sequence 0,1,2,3,4,0; retire once; 5 cycles.
- R-type 000000 then j 000010 -> 0,1,6,7,0,1,11,0; two retire pulses.
- sw with mem_ready low for 3 cycles in state 5 -> state 5 held 4 cycles, then 0; bus_err stays 0 with WAIT_MAX=8.
- FETCH with mem_ready never asserted, WAIT_MAX=8 -> state 13 after 8 wait cycles; bus_err=1; halted=1; stays until rst; rst -> state 0, flags 0.
- Opcode 111111 in DECODE -> state 13, illegal_op=1. Separately, halt_req=1 during state 7 -> next state 12, halted=1; drop halt_req -> state 0.
- MC_PERF_CNT_EN defined: run beq then addi, then halt 5 cycles -> instr_cnt=2; cycle_cnt excludes halted cycles. Repeat with CNT_W=4 over 20 cycles to check wrap.
